// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FAULT    = 2'd2
  } ctrl_state_t;

  // Register $zero never carries a real dependency.
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Number of MEM_WAIT cycles allowed without an ack before faulting.
  localparam int TIMEOUT_CYCLES_DEFAULT = 15;

endpackage

// File: rtl/mem_wait_fsm.sv
// Memory-wait sequencer: tracks whether the MEM stage is frozen on the data
// memory handshake, counts wait cycles and latches a sticky timeout fault.
module mem_wait_fsm
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
  parameter int CNT_W          = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic memop_i,
  input  logic dmem_ack_i,
  output logic dmem_req_o,
  output logic fault_o,
  output logic mem_stall_o
);

  // Counter value seen on the last MEM_WAIT cycle allowed before FAULT.
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT_CYCLES - 1);

  ctrl_state_t      state_q;
  ctrl_state_t      state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // State and wait counter registers; reset drops the request immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, counter update and the combinational stall flag.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_stall_o = 1'b0;
    case (state_q)
      RUN: begin
        if (memop_i) begin
          mem_stall_o = 1'b1;
          state_d     = MEM_WAIT;
          cnt_d       = '0;
        end
      end
      MEM_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (dmem_ack_i) begin
          state_d = RUN;
        end else begin
          mem_stall_o = 1'b1;
          if (cnt_q == LAST_WAIT) begin
            state_d = FAULT;
          end
        end
      end
      FAULT: begin
        mem_stall_o = 1'b1;
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  assign dmem_req_o = (state_q == MEM_WAIT);
  assign fault_o    = (state_q == FAULT);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline. Drives only the
// write-enable, flush and hold controls of the pipeline registers.
// Optional: define PIPE_CTRL_PERF_CNT_EN to build the stall-cycle counter.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
  parameter int CNT_W          = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic        dmem_ack_i,
  input  logic        branch_taken_i,
  input  logic        idex_memread_i,
  input  logic [4:0]  idex_rt_i,
  input  logic [4:0]  ifid_rs_i,
  input  logic [4:0]  ifid_rt_i,
  output logic        dmem_req_o,
  output logic        pc_write_o,
  output logic        ifid_write_o,
  output logic        idex_flush_o,
  output logic        ifid_flush_o,
  output logic        exmem_flush_o,
  output logic        exmem_hold_o,
  output logic        memwb_bubble_o,
  output logic        fault_o,
  output logic [31:0] stall_cycles_o
);

  logic memop;
  logic mem_stall;
  logic load_use;

  assign memop = mem_read_i | mem_write_i;

  mem_wait_fsm #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_mem_wait_fsm (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .memop_i     (memop),
    .dmem_ack_i  (dmem_ack_i),
    .dmem_req_o  (dmem_req_o),
    .fault_o     (fault_o),
    .mem_stall_o (mem_stall)
  );

  assign load_use = idex_memread_i && (idex_rt_i != REG_ZERO) &&
                    ((idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i));

  // Priority mux: memory stall (includes FAULT) over branch flush over load-use.
  always_comb begin
    pc_write_o     = 1'b1;
    ifid_write_o   = 1'b1;
    idex_flush_o   = 1'b0;
    ifid_flush_o   = 1'b0;
    exmem_flush_o  = 1'b0;
    exmem_hold_o   = 1'b0;
    memwb_bubble_o = 1'b0;
    if (mem_stall) begin
      pc_write_o     = 1'b0;
      ifid_write_o   = 1'b0;
      exmem_hold_o   = 1'b1;
      memwb_bubble_o = 1'b1;
    end else if (branch_taken_i) begin
      ifid_flush_o  = 1'b1;
      idex_flush_o  = 1'b1;
      exmem_flush_o = 1'b1;
      pc_write_o    = 1'b1;
    end else if (load_use) begin
      pc_write_o   = 1'b0;
      ifid_write_o = 1'b0;
      idex_flush_o = 1'b1;
    end
  end

`ifdef PIPE_CTRL_PERF_CNT_EN
  logic [31:0] stall_cnt_q;

  // Count every cycle in which the PC is held; wraps naturally at 2^32.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else if (!pc_write_o) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cycles_o = stall_cnt_q;
`else
  assign stall_cycles_o = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios followed by a
// randomized run, all compared against a behavioural model of the pipeline
// control rules kept in this file.
module tb_pipe_hazard_ctrl;

  localparam int TIMEOUT = 15;

  logic        clk_i;
  logic        rst_i;
  logic        mem_read_i;
  logic        mem_write_i;
  logic        dmem_ack_i;
  logic        branch_taken_i;
  logic        idex_memread_i;
  logic [4:0]  idex_rt_i;
  logic [4:0]  ifid_rs_i;
  logic [4:0]  ifid_rt_i;
  logic        dmem_req_o;
  logic        pc_write_o;
  logic        ifid_write_o;
  logic        idex_flush_o;
  logic        ifid_flush_o;
  logic        exmem_flush_o;
  logic        exmem_hold_o;
  logic        memwb_bubble_o;
  logic        fault_o;
  logic [31:0] stall_cycles_o;

  pipe_hazard_ctrl #(
    .TIMEOUT_CYCLES (TIMEOUT),
    .CNT_W          (4)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .mem_read_i     (mem_read_i),
    .mem_write_i    (mem_write_i),
    .dmem_ack_i     (dmem_ack_i),
    .branch_taken_i (branch_taken_i),
    .idex_memread_i (idex_memread_i),
    .idex_rt_i      (idex_rt_i),
    .ifid_rs_i      (ifid_rs_i),
    .ifid_rt_i      (ifid_rt_i),
    .dmem_req_o     (dmem_req_o),
    .pc_write_o     (pc_write_o),
    .ifid_write_o   (ifid_write_o),
    .idex_flush_o   (idex_flush_o),
    .ifid_flush_o   (ifid_flush_o),
    .exmem_flush_o  (exmem_flush_o),
    .exmem_hold_o   (exmem_hold_o),
    .memwb_bubble_o (memwb_bubble_o),
    .fault_o        (fault_o),
    .stall_cycles_o (stall_cycles_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int req_seen = 0;

  // Behavioural model: "is a memory access outstanding", how many wait cycles
  // have elapsed, whether the timeout has latched, and cycles with PC held.
  bit          m_waiting;
  int          m_waited;
  bit          m_faulted;
  logic [31:0] m_stalls;
  bit          e_pc_last;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    m_waiting = 1'b0;
    m_waited  = 0;
    m_faulted = 1'b0;
    m_stalls  = 32'd0;
  endtask

  task automatic applyStimulus(input bit mr, input bit mw, input bit ack, input bit br,
                               input bit lmr, input logic [4:0] lrt,
                               input logic [4:0] rs, input logic [4:0] rt);
    mem_read_i     = mr;
    mem_write_i    = mw;
    dmem_ack_i     = ack;
    branch_taken_i = br;
    idex_memread_i = lmr;
    idex_rt_i      = lrt;
    ifid_rs_i      = rs;
    ifid_rt_i      = rt;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
  endtask

  // Compare every output against what the pipeline rules demand right now.
  task automatic checkOutput(input string tag);
    bit frozen;
    bit hazard;
    bit e_pc, e_ifw, e_idf, e_iff, e_exf, e_hold, e_bub;
    logic [31:0] e_perf;
    if (m_faulted)      frozen = 1'b1;
    else if (m_waiting) frozen = !dmem_ack_i;
    else                frozen = mem_read_i || mem_write_i;
    hazard = idex_memread_i && (idex_rt_i != 5'd0) &&
             (idex_rt_i == ifid_rs_i || idex_rt_i == ifid_rt_i);
    {e_pc, e_ifw, e_idf, e_iff, e_exf, e_hold, e_bub} = 7'b1100000;
    if (frozen)              {e_pc, e_ifw, e_hold, e_bub} = 4'b0011;
    else if (branch_taken_i) {e_idf, e_iff, e_exf} = 3'b111;
    else if (hazard)         {e_pc, e_ifw, e_idf} = 3'b001;
`ifdef PIPE_CTRL_PERF_CNT_EN
    e_perf = m_stalls;
`else
    e_perf = 32'd0;
`endif
    checkVal({tag, ".pc_write"},     {31'd0, pc_write_o},     {31'd0, e_pc});
    checkVal({tag, ".ifid_write"},   {31'd0, ifid_write_o},   {31'd0, e_ifw});
    checkVal({tag, ".idex_flush"},   {31'd0, idex_flush_o},   {31'd0, e_idf});
    checkVal({tag, ".ifid_flush"},   {31'd0, ifid_flush_o},   {31'd0, e_iff});
    checkVal({tag, ".exmem_flush"},  {31'd0, exmem_flush_o},  {31'd0, e_exf});
    checkVal({tag, ".exmem_hold"},   {31'd0, exmem_hold_o},   {31'd0, e_hold});
    checkVal({tag, ".memwb_bubble"}, {31'd0, memwb_bubble_o}, {31'd0, e_bub});
    checkVal({tag, ".dmem_req"},     {31'd0, dmem_req_o},     {31'd0, m_waiting});
    checkVal({tag, ".fault"},        {31'd0, fault_o},        {31'd0, m_faulted});
    checkVal({tag, ".stall_cycles"}, stall_cycles_o,          e_perf);
    e_pc_last = e_pc;
  endtask

  // Advance the model by one clock edge using the inputs of the cycle.
  task automatic modelStep();
    if (!e_pc_last) m_stalls = m_stalls + 32'd1;
    if (m_faulted) begin
      // sticky until reset
    end else if (m_waiting) begin
      if (dmem_ack_i) begin
        m_waiting = 1'b0;
      end else if (m_waited + 1 == TIMEOUT) begin
        m_waiting = 1'b0;
        m_faulted = 1'b1;
      end else begin
        m_waited = m_waited + 1;
      end
    end else if (mem_read_i || mem_write_i) begin
      m_waiting = 1'b1;
      m_waited  = 0;
    end
  endtask

  // One clock: check at the falling edge, step the model at the rising edge.
  task automatic runCycle(input string tag);
    @(negedge clk_i);
    checkOutput(tag);
    if (dmem_req_o === 1'b1) req_seen++;
    @(posedge clk_i);
    modelStep();
    #1;
  endtask

  task automatic doReset();
    rst_i = 1'b1;
    idle();
    modelReset();
    #2;
    checkOutput("reset");
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b0;
    idle();
    modelReset();
    e_pc_last = 1'b1;
    #1;
    doReset();

    // Load with ack on the third MEM_WAIT cycle.
    req_seen = 0;
    applyStimulus(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    runCycle("load_entry");
    runCycle("load_w1");
    runCycle("load_w2");
    applyStimulus(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0);
    runCycle("load_ack");
    idle();
    runCycle("load_after");
    checkVal("load_req_cycles", req_seen, 32'd3);

    // Load-use on rs, then the same with rt=$zero.
    applyStimulus(0, 0, 0, 0, 1, 5'd8, 5'd8, 5'd3);
    runCycle("lu_rs");
    applyStimulus(0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0);
    runCycle("lu_zero");
    applyStimulus(0, 0, 0, 0, 1, 5'd9, 5'd1, 5'd9);
    runCycle("lu_rt");
    idle();
    runCycle("lu_after");

    // Branch pulse while idle, also masking a load-use.
    applyStimulus(0, 0, 0, 1, 1, 5'd4, 5'd4, 5'd0);
    runCycle("branch");
    idle();
    runCycle("branch_after");

    // Ack in RUN is ignored.
    applyStimulus(0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0);
    runCycle("stray_ack");

    // Store together with branch: stall first, branch on the ack cycle.
    applyStimulus(0, 1, 0, 1, 1, 5'd7, 5'd7, 5'd0);
    runCycle("st_br_entry");
    runCycle("st_br_w1");
    applyStimulus(0, 1, 1, 1, 1, 5'd7, 5'd7, 5'd0);
    runCycle("st_br_ack");
    idle();
    runCycle("st_br_after");

    // Load-use hidden during a stall, applied on release.
    applyStimulus(1, 0, 0, 0, 1, 5'd5, 5'd5, 5'd5);
    runCycle("lu_stall_entry");
    applyStimulus(1, 0, 1, 0, 1, 5'd5, 5'd5, 5'd5);
    runCycle("lu_stall_ack");
    idle();
    runCycle("lu_stall_after");

    // Perf counter: 4 mem-stall cycles plus one load-use.
    doReset();
    applyStimulus(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    for (int i = 0; i < 4; i++) runCycle("perf_wait");
    applyStimulus(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0);
    runCycle("perf_ack");
    applyStimulus(0, 0, 0, 0, 1, 5'd12, 5'd0, 5'd12);
    runCycle("perf_lu");
    idle();
    runCycle("perf_idle");
`ifdef PIPE_CTRL_PERF_CNT_EN
    checkVal("perf_total", stall_cycles_o, 32'd5);
`else
    checkVal("perf_total", stall_cycles_o, 32'd0);
`endif

    // Randomized traffic.
    doReset();
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
                    $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0,
                    $urandom_range(0, 1) == 0, 5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      runCycle("random");
    end

    // Store with no ack: timeout into FAULT, sticky until reset.
    doReset();
    applyStimulus(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    runCycle("to_entry");
    for (int i = 0; i < TIMEOUT; i++) runCycle("to_wait");
    #1;
    checkVal("to_fault_set", {31'd0, fault_o}, 32'd1);
    checkVal("to_req_drop", {31'd0, dmem_req_o}, 32'd0);
    applyStimulus(0, 0, 1, 1, 0, 5'd0, 5'd0, 5'd0);
    for (int i = 0; i < 5; i++) runCycle("to_sticky");
    checkVal("to_fault_sticky", {31'd0, fault_o}, 32'd1);
    doReset();
    checkVal("to_fault_clear", {31'd0, fault_o}, 32'd0);

    // Asynchronous reset on the second MEM_WAIT cycle.
    applyStimulus(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    runCycle("ar_entry");
    runCycle("ar_w1");
    #2;
    checkVal("ar_req_before", {31'd0, dmem_req_o}, 32'd1);
    rst_i = 1'b1;
    #1;
    checkVal("ar_req_async", {31'd0, dmem_req_o}, 32'd0);
    checkVal("ar_fault_async", {31'd0, fault_o}, 32'd0);
    idle();
    modelReset();
    #1;
    checkOutput("ar_idle");
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    runCycle("ar_run");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
